qout_capture_fifo: RTL and testbench
====================================

Name: qout_capture_fifo

Overview:
- Synchronous FIFO that sits directly downstream of the 8-bit flipflop stage.
- Captures each qout word that is marked valid and holds it until a consumer accepts it.
- Decouples the free-running register stage from slower consumers, using valid/ready handshakes on both sides.
- Reports occupancy and a sticky overflow flag for words lost while the FIFO was full.

Parameters:
WIDTH, 8, data width; matches the flipflop qout width.
DEPTH, 8, number of entries; must be a power of two and at least 2.
CW, $clog2(DEPTH)+1, derived width of the count output; not overridden by users.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
din  input  WIDTH  write data, fed from flipflop qout.
din_valid  input  1  write request for din.
din_ready  output  1  FIFO can accept a word; equals !full.
dout  output  WIDTH  head-of-queue data; first-word fall-through.
dout_valid  output  1  head word present; equals !empty.
dout_ready  input  1  consumer accepts the head word this cycle.
count  output  CW  number of stored words, 0..DEPTH.
overflow  output  1  sticky; a write was attempted while full.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values, effective the cycle after reset is sampled high:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - dout_valid = 0, din_ready = 1, overflow = 0, dout = 0.
  - Storage array is not reset.
- Write accept: on a rising edge with din_valid && din_ready, din is stored at mem[wr_ptr], wr_ptr increments, and count increments.
- Read accept: on a rising edge with dout_ready && dout_valid, rd_ptr increments and count decrements.
- Output data:
  - dout = mem[rd_ptr] combinationally while dout_valid = 1; dout = 0 while empty.
  - Write-to-read latency is 1 cycle: a word written into an empty FIFO appears on dout, with dout_valid = 1, in the cycle after the write edge.
  - There is no same-cycle bypass from din to dout.
- Pointers: log2(DEPTH) bits wide and wrap modulo DEPTH with no special-case logic.
- Full and empty:
  - full = (count == DEPTH); empty = (count == 0).
  - count is the authoritative occupancy; pointer-MSB comparison is not used.
- Simultaneous read and write, with neither refused: both happen, count is unchanged, and both pointers advance.
- Write while full: din_ready = 0, so the write is refused even if a read happens in the same cycle. There is no pass-through when full. Overflow sets the following cycle.
- Read while empty: dout_valid = 0, so the read is ignored and count stays at 0. A simultaneous write still proceeds.
- Overflow: set on any edge where din_valid = 1 and full = 1. It stays set until reset and is unaffected by later reads.
- Reset mid-operation: all stored words are discarded. The FIFO is empty in the next cycle regardless of din_valid or dout_ready during the reset cycle, and no write is accepted in the reset cycle.
- Outputs din_ready, dout_valid and count are driven from registered state only. There is no combinational path from din_valid or dout_ready to any output.

Decomposition:
- Package fifo_pkg:
  - localparam FIFO_WIDTH = 8 and FIFO_DEPTH = 8.
  - typedef logic [FIFO_WIDTH-1:0] data_t.
  - A function returning $clog2(depth)+1 for sizing count.
- One sub-module, fifo_mem:
  - DEPTH x WIDTH register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flag control stays in qout_capture_fifo.

Test Plan:
1. Reset, then hold idle for 3 cycles -> count = 0, dout_valid = 0, din_ready = 1, overflow = 0, dout = 0.
2. Write 1, 2, 4, 8, 16, 32, 64, 128 on consecutive cycles with dout_ready = 0 -> count steps 1..8; din_ready = 0 after the 8th write; dout = 1 from the cycle after the first write.
3. From full, assert din_valid with din = 8'hAA for 1 cycle, then drain with dout_ready = 1 -> overflow = 1 and stays set; dout sequence is 1, 2, 4, ..., 128; 8'hAA never appears; empty after 8 reads.
4. Fill to count = 3, then drive din_valid = 1 and dout_ready = 1 together for 10 cycles with incrementing data -> count stays at 3 throughout; output order equals input order across pointer wrap-around.
5. From empty, assert dout_ready = 1 and din_valid = 1 with din = 8'h55 in the same cycle -> count = 1; dout = 8'h55 with dout_valid = 1 on the next cycle; the read in the empty cycle is ignored.
6. With count = 5 and overflow = 1, assert reset for 1 cycle while din_valid = 1 -> next cycle count = 0, overflow = 0, dout_valid = 0; the word presented during reset is not stored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the qout capture FIFO.
// Defaults match the 8-bit flipflop stage feeding the FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    typedef logic [FIFO_WIDTH-1:0] data_t;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/qout_capture_fifo.sv
// First-word fall-through FIFO capturing valid qout words; write-to-read latency 1 cycle.
// Backpressure: din_ready = !full, dout_valid = !empty, both from registered count; writes while full are dropped and flagged.
module qout_capture_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] rdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A read in the same cycle never frees a slot for a write: no pass-through when full.
    assign wr_en = din_valid && !full && !reset;
    assign rd_en = dout_ready && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (din_valid && full);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign din_ready  = !full;
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : rdata;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_qout_capture_fifo.sv
// Directed vector table for the main scenarios, then queue-model checked sequences and random traffic.
module tb_qout_capture_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] count;
    logic          overflow;

    always #5 clk = ~clk;

    qout_capture_fifo #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .overflow   (overflow)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         rst;
        logic         dv;
        logic [W-1:0] d;
        logic         dr;
        int           cnt;
        logic         vld;
        logic         rdy;
        logic [W-1:0] dq;
        logic         ovf;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] mq[$];
    logic         movf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic dv, input logic [W-1:0] d,
                                input logic dr, input int cnt, input logic vld,
                                input logic rdy, input logic [W-1:0] dq, input logic ovf);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.dr = dr;
        v.cnt = cnt; v.vld = vld; v.rdy = rdy; v.dq = dq; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the FIFO is a bounded queue; pops happen only when non-empty, pushes only when not full.
    task automatic cycle(input logic r, input logic dv, input logic [W-1:0] d, input logic dr);
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        reset = r; din_valid = dv; din = d; dout_ready = dr;
        if (r) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (dv && was_full) movf = 1'b1;
            if (dr && !was_empty) void'(mq.pop_front());
            if (dv && !was_full) mq.push_back(d);
        end
        step();
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_dout_valid", 32'(dout_valid), 32'(mq.size() != 0));
        chk("m_din_ready", 32'(din_ready), 32'(mq.size() != D));
        chk("m_dout", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk("m_overflow", 32'(overflow), 32'(movf));
    endtask

    initial begin
        logic [W-1:0] v8;
        reset = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
        movf = 1'b0;

        // Reset and idle.
        add(1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0);
        // Fill with one-hot words; head stays at the first word.
        for (int i = 0; i < 8; i++) begin
            v8 = 8'(1 << i);
            add(0, 1, v8, 0, i + 1, 1, (i < 7), 8'h01, 0);
        end
        // Write while full is dropped and flagged; then drain in order.
        add(0, 1, 8'hAA, 0, 8, 1, 0, 8'h01, 1);
        for (int k = 1; k <= 8; k++) begin
            v8 = (k < 8) ? 8'(1 << k) : 8'h00;
            add(0, 0, 8'h00, 1, 8 - k, (k < 8), 1, v8, 1);
        end
        // Read attempted while empty is ignored, concurrent write lands.
        add(0, 1, 8'h55, 1, 1, 1, 1, 8'h55, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 8'(8'h10 + i), 0, 2 + i, 1, 1, 8'h55, 1);
        // Reset with a write presented: nothing stored.
        add(1, 1, 8'h77, 0, 0, 0, 1, 8'h00, 0);
        add(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; din_valid = vecs[i].dv; din = vecs[i].d; dout_ready = vecs[i].dr;
            step();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_dout_valid", i), 32'(dout_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_din_ready", i), 32'(din_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].dq));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Steady-state simultaneous read/write at count 3 across pointer wrap.
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'hC0 + i), 0);
        for (int i = 0; i < 10; i++) begin
            v8 = 8'(8'hC0 + i);
            chk("wrap_head", 32'(dout), 32'(v8));
            cycle(0, 1, 8'(8'hC3 + i), 1);
            chk("wrap_count3", 32'(count), 32'd3);
        end

        // Random traffic with alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                logic r, dv, dr;
                r  = ($urandom_range(0, 79) == 0);
                dv = ph[0] ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
                dr = ph[0] ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
                cycle(r, dv, 8'($urandom), dr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
